mem_port_arbiter: RTL and testbench

// - Shares the single external memory port between I-cache and D-cache refill/writeback bursts.
// - Sits between both caches (started by the main control FSM) and the memory interface.
// - Round-robin grant per whole burst; latches address/direction; counts beats; signals completion.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between I-cache and D-cache bursts.
// Each whole burst is granted round-robin; the address and direction are latched, and the beats are counted.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_i_req,
    input  logic [ADDR_WIDTH-1:0] i_i_addr,
    output logic                  o_i_grant,
    output logic                  o_i_rvalid,
    output logic [DATA_WIDTH-1:0] o_i_rdata,
    output logic                  o_i_done,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [ADDR_WIDTH-1:0] i_d_addr,
    input  logic [DATA_WIDTH-1:0] i_d_wdata,
    output logic                  o_d_grant,
    output logic                  o_d_wready,
    output logic                  o_d_rvalid,
    output logic [DATA_WIDTH-1:0] o_d_rdata,
    output logic                  o_d_done,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_ready,
    output logic                  o_mem_wvalid,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_wready,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    localparam int CNT_W = $clog2(BURST_LEN);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    owner_d_reg, owner_d_next;   // 1 = D-cache owns the burst
    logic                    last_d_reg, last_d_next;     // 1 = D-cache was served last
    logic                    we_reg, we_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic                    pick_d;
    logic                    beat;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            owner_d_reg <= 1'b0;
            last_d_reg  <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            owner_d_reg <= owner_d_next;
            last_d_reg  <= last_d_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
        end
    end

    // On a tie, serve whichever requester was not served last.
    assign pick_d = i_d_req && (!i_i_req || !last_d_reg);
    assign beat   = we_reg ? i_mem_wready : i_mem_rvalid;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        owner_d_next = owner_d_reg;
        last_d_next  = last_d_reg;
        we_next      = we_reg;
        addr_next    = addr_reg;
        case (state_reg)
            IDLE: begin
                if (i_i_req || i_d_req) begin
                    owner_d_next = pick_d;
                    we_next      = pick_d & i_d_we;
                    addr_next    = pick_d ? i_d_addr : i_i_addr;
                    state_next   = ADDR;
                end
            end
            ADDR: begin
                if (i_mem_ready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    if (cnt_reg == CNT_W'(BURST_LEN - 1)) begin
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                last_d_next = owner_d_reg;
                cnt_next    = '0;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    logic busy;
    logic rd_phase;
    logic wr_phase;

    assign busy     = (state_reg != IDLE);
    assign rd_phase = (state_reg == DATA) && !we_reg;
    assign wr_phase = (state_reg == DATA) && we_reg;

    assign o_i_grant    = busy && !owner_d_reg;
    assign o_d_grant    = busy && owner_d_reg;
    assign o_i_done     = (state_reg == DONE) && !owner_d_reg;
    assign o_d_done     = (state_reg == DONE) && owner_d_reg;

    // Read beats reach only the owner, and only during a read burst's data phase.
    assign o_i_rvalid   = rd_phase && !owner_d_reg && i_mem_rvalid;
    assign o_d_rvalid   = rd_phase && owner_d_reg && i_mem_rvalid;
    assign o_i_rdata    = (rd_phase && !owner_d_reg) ? i_mem_rdata : '0;
    assign o_d_rdata    = (rd_phase && owner_d_reg) ? i_mem_rdata : '0;

    assign o_mem_req    = (state_reg == ADDR);
    assign o_mem_we     = busy && we_reg;
    assign o_mem_addr   = addr_reg;
    assign o_mem_wvalid = wr_phase;
    assign o_mem_wdata  = wr_phase ? i_d_wdata : '0;
    assign o_d_wready   = wr_phase && i_mem_wready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard testbench for mem_port_arbiter: a small memory model drives the port,
// and each read/write beat it expects is queued and checked when the arbiter presents it.
module tb_mem_port_arbiter;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int BL = 16;

    logic          clk = 1'b0;
    logic          arst;
    logic          i_i_req;
    logic [AW-1:0] i_i_addr;
    logic          o_i_grant, o_i_rvalid, o_i_done;
    logic [DW-1:0] o_i_rdata;
    logic          i_d_req, i_d_we;
    logic [AW-1:0] i_d_addr;
    logic [DW-1:0] i_d_wdata;
    logic          o_d_grant, o_d_wready, o_d_rvalid, o_d_done;
    logic [DW-1:0] o_d_rdata;
    logic          o_mem_req, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic          i_mem_ready;
    logic          o_mem_wvalid;
    logic [DW-1:0] o_mem_wdata;
    logic          i_mem_wready, i_mem_rvalid;
    logic [DW-1:0] i_mem_rdata;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .arst(arst),
        .i_i_req(i_i_req), .i_i_addr(i_i_addr), .o_i_grant(o_i_grant),
        .o_i_rvalid(o_i_rvalid), .o_i_rdata(o_i_rdata), .o_i_done(o_i_done),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
        .o_d_grant(o_d_grant), .o_d_wready(o_d_wready), .o_d_rvalid(o_d_rvalid),
        .o_d_rdata(o_d_rdata), .o_d_done(o_d_done),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .i_mem_ready(i_mem_ready), .o_mem_wvalid(o_mem_wvalid), .o_mem_wdata(o_mem_wdata),
        .i_mem_wready(i_mem_wready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One whole burst; the caller has just raised the request(s) after a negedge.
    // pat: 0 = beat every cycle, 1 = beat on alternate cycles. Returns cycles from IDLE to DONE.
    task automatic burst(input bit exp_d, input bit we, input logic [AW-1:0] exp_addr,
                         input int ready_dly, input int pat, output int ncyc);
        logic [1:0]    exp_gnt;
        logic [DW-1:0] cur_w;
        logic [DW-1:0] exp_v;
        logic          v, obs_rv, oth_rv;
        logic [DW-1:0] obs_rd;
        int beats;
        int cyc;
        exp_gnt = exp_d ? 2'b10 : 2'b01;
        ncyc = 0;
        #1;
        checks++;
        if ({o_d_grant, o_i_grant, o_mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL idle_no_grant: got %b want 000", {o_d_grant, o_i_grant, o_mem_req});
        end
        @(negedge clk); ncyc++;
        for (int w = 0; w <= ready_dly; w++) begin
            i_mem_ready = (w == ready_dly);
            if (w == 2) begin
                i_d_addr = ~i_d_addr;
                i_i_addr = ~i_i_addr;
                i_d_we   = ~i_d_we;
            end
            #1;
            checks++;
            if ({o_mem_req, o_mem_we, o_mem_addr} !== {1'b1, we, exp_addr}) begin
                errors++;
                $display("FAIL addr_phase: got req=%b we=%b addr=%h want req=1 we=%b addr=%h",
                         o_mem_req, o_mem_we, o_mem_addr, we, exp_addr);
            end
            checks++;
            if ({o_d_grant, o_i_grant} !== exp_gnt) begin
                errors++;
                $display("FAIL addr_grant: got %b want %b", {o_d_grant, o_i_grant}, exp_gnt);
            end
            @(negedge clk); ncyc++;
        end
        i_mem_ready = 1'b0;
        beats = 0;
        cyc = 0;
        cur_w = $urandom;
        while (beats < BL && cyc < 200) begin
            v = (pat == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (we) begin
                i_mem_wready = v;
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = $urandom;
                i_d_wdata    = cur_w;
                if (v) sb_q.push_back(cur_w);
            end else begin
                i_mem_rvalid = v;
                i_mem_rdata  = $urandom;
                if (v) sb_q.push_back(i_mem_rdata);
            end
            #1;
            obs_rv = exp_d ? o_d_rvalid : o_i_rvalid;
            oth_rv = exp_d ? o_i_rvalid : o_d_rvalid;
            obs_rd = exp_d ? o_d_rdata : o_i_rdata;
            checks++;
            if ({o_d_grant, o_i_grant, o_mem_req, o_i_done, o_d_done} !== {exp_gnt, 3'b000}) begin
                errors++;
                $display("FAIL data_ctrl: beat %0d got %b want %b", beats,
                         {o_d_grant, o_i_grant, o_mem_req, o_i_done, o_d_done}, {exp_gnt, 3'b000});
            end
            if (we) begin
                checks++;
                if ({o_mem_wvalid, o_d_wready, o_i_rvalid, o_d_rvalid} !== {1'b1, v, 2'b00}) begin
                    errors++;
                    $display("FAIL wr_handshake: beat %0d got %b want %b", beats,
                             {o_mem_wvalid, o_d_wready, o_i_rvalid, o_d_rvalid}, {1'b1, v, 2'b00});
                end
                if (v) begin
                    exp_v = sb_q.pop_front();
                    checks++;
                    if (o_mem_wdata !== exp_v) begin
                        errors++;
                        $display("FAIL wr_data: beat %0d got %h want %h", beats, o_mem_wdata, exp_v);
                    end
                    cur_w = $urandom;
                end
            end else begin
                checks++;
                if ({obs_rv, oth_rv, o_mem_wvalid} !== {v, 2'b00}) begin
                    errors++;
                    $display("FAIL rd_valid: beat %0d got %b want %b", beats,
                             {obs_rv, oth_rv, o_mem_wvalid}, {v, 2'b00});
                end
                if (v) begin
                    exp_v = sb_q.pop_front();
                    checks++;
                    if (obs_rd !== exp_v) begin
                        errors++;
                        $display("FAIL rd_data: beat %0d got %h want %h", beats, obs_rd, exp_v);
                    end
                end
            end
            if (v) beats++;
            cyc++;
            @(negedge clk); ncyc++;
        end
        if (beats < BL) begin
            errors++;
            $display("FAIL data_timeout: got %0d beats want %0d", beats, BL);
        end
        i_mem_wready = 1'b0;
        i_mem_rvalid = 1'b0;
        if (exp_d) i_d_req = 1'b0; else i_i_req = 1'b0;
        #1;
        checks++;
        if ({o_d_done, o_i_done, o_d_grant, o_i_grant} !== {exp_gnt, exp_gnt}) begin
            errors++;
            $display("FAIL done_pulse: got %b want %b",
                     {o_d_done, o_i_done, o_d_grant, o_i_grant}, {exp_gnt, exp_gnt});
        end
        @(negedge clk);
        $display("burst owner=%s we=%0d addr=%h cycles=%0d", exp_d ? "D" : "I", we, exp_addr, ncyc);
    endtask

    task automatic test_reset();
        arst = 1'b1;
        i_i_req = 0; i_d_req = 0; i_d_we = 0;
        i_i_addr = '0; i_d_addr = '0; i_d_wdata = '0;
        i_mem_ready = 0; i_mem_wready = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
        repeat (3) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (|{o_i_grant, o_i_rvalid, o_i_rdata, o_i_done, o_d_grant, o_d_wready, o_d_rvalid,
              o_d_rdata, o_d_done, o_mem_req, o_mem_we, o_mem_addr, o_mem_wvalid, o_mem_wdata} !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero, want all 0");
        end
        $display("reset released, outputs checked");
    endtask

    task automatic test_tie();
        int n;
        @(negedge clk);
        i_i_addr = 64'h0000_1000_0000_0040;
        i_d_addr = 64'h0000_2000_0000_0080;
        i_d_we = 1'b0;
        i_i_req = 1'b1; i_d_req = 1'b1;
        burst(1'b1, 1'b0, 64'h0000_2000_0000_0080, 0, 0, n);
        burst(1'b0, 1'b0, 64'h0000_1000_0000_0040, 0, 0, n);
        i_d_addr = 64'h0000_3000_0000_00C0;
        i_i_addr = 64'h0000_4000_0000_0100;
        i_i_req = 1'b1; i_d_req = 1'b1;
        burst(1'b1, 1'b0, 64'h0000_3000_0000_00C0, 0, 0, n);
        burst(1'b0, 1'b0, 64'h0000_4000_0000_0100, 0, 0, n);
    endtask

    task automatic test_i_read();
        int n;
        i_i_addr = 64'hDEAD_BEEF_0000_0200;
        i_i_req = 1'b1;
        burst(1'b0, 1'b0, 64'hDEAD_BEEF_0000_0200, 0, 0, n);
        checks++;
        if (n != 18) begin
            errors++;
            $display("FAIL i_read_latency: done at cycle %0d want 18", n);
        end
    endtask

    task automatic test_d_write();
        int n;
        i_d_addr = 64'h0000_0000_CAFE_0300;
        i_d_we = 1'b1;
        i_d_req = 1'b1;
        burst(1'b1, 1'b1, 64'h0000_0000_CAFE_0300, 0, 1, n);
        i_d_we = 1'b0;
    endtask

    task automatic test_addr_stall();
        int n;
        i_d_addr = 64'h1234_5678_9ABC_0400;
        i_d_we = 1'b0;
        i_d_req = 1'b1;
        burst(1'b1, 1'b0, 64'h1234_5678_9ABC_0400, 5, 1, n);
        i_d_we = 1'b0;
    endtask

    task automatic test_spurious();
        for (int c = 0; c < 3; c++) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata = $urandom;
            #1;
            checks++;
            if ({o_i_rvalid, o_d_rvalid, o_i_grant, o_d_grant} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_rvalid: got %b want 0000",
                         {o_i_rvalid, o_d_rvalid, o_i_grant, o_d_grant});
            end
            @(negedge clk);
        end
        i_mem_rvalid = 1'b0;
        $display("spurious rvalid in idle checked");
    endtask

    task automatic test_reset_abort();
        int n;
        i_i_addr = 64'h0000_0000_0000_0500;
        i_i_req = 1'b1;
        @(negedge clk);
        i_mem_ready = 1'b1;
        @(negedge clk);
        i_mem_ready = 1'b0;
        for (int b = 0; b < 7; b++) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata = $urandom;
            #1;
            checks++;
            if (o_i_rvalid !== 1'b1 || o_i_rdata !== i_mem_rdata) begin
                errors++;
                $display("FAIL abort_beat: beat %0d got v=%b d=%h want v=1 d=%h",
                         b, o_i_rvalid, o_i_rdata, i_mem_rdata);
            end
            @(negedge clk);
        end
        i_mem_rvalid = 1'b0;
        i_i_req = 1'b0;
        arst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (|{o_i_grant, o_i_rvalid, o_i_rdata, o_i_done, o_d_grant, o_d_wready, o_d_rvalid,
              o_d_rdata, o_d_done, o_mem_req, o_mem_we, o_mem_addr, o_mem_wvalid, o_mem_wdata} !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: some output nonzero after reset, want all 0");
        end
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        $display("reset abort after 7 beats checked");
        i_i_addr = 64'h0000_0000_0000_0600;
        i_i_req = 1'b1;
        burst(1'b0, 1'b0, 64'h0000_0000_0000_0600, 0, 0, n);
    endtask

    initial begin
        test_reset();
        test_tie();
        test_i_read();
        test_d_write();
        test_addr_stall();
        test_spurious();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
